// File: rtl/arcade_iir_filter.sv
// Stereo 3rd-order IIR low-pass with a self-generated sample tick.
// Both channels share one multiplier, stepped five cycles per channel.
module arcade_iir_filter #(
  parameter int unsigned CLK_HZ   = 74250000,
  parameter int unsigned CX_SHIFT = 40,
  parameter int unsigned CY_SHIFT = 21
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flt_en,
  input  logic [31:0]        flt_rate,
  input  logic [39:0]        cx,
  input  logic [7:0]         cx0,
  input  logic [7:0]         cx1,
  input  logic [7:0]         cx2,
  input  logic signed [23:0] cy0,
  input  logic signed [23:0] cy1,
  input  logic signed [23:0] cy2,
  input  logic signed [15:0] in_l,
  input  logic signed [15:0] in_r,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic               out_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned SMP_W  = 16;
  localparam int unsigned XS_W   = 27;
  localparam int unsigned OPA_W  = 41;
  localparam int unsigned PROD_W = 68;
  localparam int unsigned ACC_W  = 64;
  localparam int unsigned DIFF_W = 69;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC_L = 2'd1,
    S_CALC_R = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]              r_phase;
  logic [2:0]               r_step;
  logic                     r_en;
  logic [39:0]              r_cx;
  logic [7:0]               r_cx0, r_cx1, r_cx2;
  logic signed [23:0]       r_cy0, r_cy1, r_cy2;
  logic signed [SMP_W-1:0]  r_in [2];
  logic signed [SMP_W-1:0]  r_xh [2][3];
  logic signed [SMP_W-1:0]  r_yh [2][3];
  logic signed [PROD_W-1:0] r_acc_a;
  logic signed [ACC_W-1:0]  r_acc_f;
  logic signed [SMP_W-1:0]  r_y_l;
  logic signed [SMP_W-1:0]  r_out_l, r_out_r;
  logic                     r_out_valid, r_busy, r_overrun;

  logic [32:0]              w_sum;
  logic                     w_tick;
  logic                     w_calc;
  logic                     w_ch;
  logic signed [SMP_W-1:0]  w_xcur;
  logic signed [XS_W-1:0]   w_tap0, w_tap1, w_tap2, w_xs;
  logic signed [OPA_W-1:0]  w_op_a;
  logic signed [XS_W-1:0]   w_op_b;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_fs;
  logic signed [DIFF_W-1:0] w_ydiff;
  logic signed [SMP_W-1:0]  w_ysat, w_yout;

  assign out_l     = r_out_l;
  assign out_r     = r_out_r;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

  // Fractional tick: 33-bit sum so a large rate cannot wrap before compare
  assign w_sum  = {1'b0, r_phase} + {1'b0, flt_rate};
  assign w_tick = (w_sum >= 33'(CLK_HZ));

  assign w_calc = (r_state == S_CALC_L) || (r_state == S_CALC_R);
  assign w_ch   = (r_state == S_CALC_R);
  assign w_xcur = r_in[w_ch];

  // Feed-forward sum for the active channel (taps are unsigned)
  assign w_tap0 = XS_W'($signed({1'b0, r_cx0})) * XS_W'(r_xh[w_ch][0]);
  assign w_tap1 = XS_W'($signed({1'b0, r_cx1})) * XS_W'(r_xh[w_ch][1]);
  assign w_tap2 = XS_W'($signed({1'b0, r_cx2})) * XS_W'(r_xh[w_ch][2]);
  assign w_xs   = XS_W'(w_xcur) + w_tap0 + w_tap1 + w_tap2;

  // Shared multiplier operand select: step 0 gain, steps 1-3 feedback taps
  always_comb begin
    w_op_a = $signed({1'b0, r_cx});
    w_op_b = w_xs;
    case (r_step)
      3'd1: begin
        w_op_a = OPA_W'(r_cy0);
        w_op_b = XS_W'(r_yh[w_ch][0]);
      end
      3'd2: begin
        w_op_a = OPA_W'(r_cy1);
        w_op_b = XS_W'(r_yh[w_ch][1]);
      end
      3'd3: begin
        w_op_a = OPA_W'(r_cy2);
        w_op_b = XS_W'(r_yh[w_ch][2]);
      end
      default: ;
    endcase
  end

  assign w_prod  = PROD_W'(w_op_a) * PROD_W'(w_op_b);
  assign w_fs    = r_acc_f >>> CY_SHIFT;
  assign w_ydiff = DIFF_W'(r_acc_a) - DIFF_W'(w_fs);

  // Clamp the filter result to the 16-bit sample range
  always_comb begin
    w_ysat = SMP_W'(w_ydiff);
    if (w_ydiff > 69'sd32767) begin
      w_ysat = 16'sh7fff;
    end else if (w_ydiff < -69'sd32768) begin
      w_ysat = 16'sh8000;
    end
  end

  assign w_yout = r_en ? w_ysat : w_xcur;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_tick) w_next = S_CALC_L;
      S_CALC_L: if (r_step == 3'd4) w_next = S_CALC_R;
      S_CALC_R: if (r_step == 3'd4) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Phase accumulator, snapshot, MAC sequence, history and outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_phase     <= '0;
      r_step      <= '0;
      r_en        <= 1'b0;
      r_cx        <= '0;
      r_cx0       <= '0;
      r_cx1       <= '0;
      r_cx2       <= '0;
      r_cy0       <= '0;
      r_cy1       <= '0;
      r_cy2       <= '0;
      r_acc_a     <= '0;
      r_acc_f     <= '0;
      r_y_l       <= '0;
      r_out_l     <= '0;
      r_out_r     <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        r_in[c] <= '0;
        for (int k = 0; k < 3; k++) begin
          r_xh[c][k] <= '0;
          r_yh[c][k] <= '0;
        end
      end
    end else begin
      r_phase     <= w_tick ? 32'(w_sum - 33'(CLK_HZ)) : w_sum[31:0];
      r_busy      <= (w_next != S_IDLE);
      r_out_valid <= (w_next == S_DONE);

      if (w_tick && (r_state == S_IDLE)) begin
        r_en    <= flt_en;
        r_cx    <= cx;
        r_cx0   <= cx0;
        r_cx1   <= cx1;
        r_cx2   <= cx2;
        r_cy0   <= cy0;
        r_cy1   <= cy1;
        r_cy2   <= cy2;
        r_in[0] <= in_l;
        r_in[1] <= in_r;
      end
      if (w_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      if (w_calc) begin
        r_step <= (r_step == 3'd4) ? 3'd0 : 3'(r_step + 3'd1);
        case (r_step)
          3'd0: begin
            r_acc_a <= w_prod >>> CX_SHIFT;
            r_acc_f <= '0;
          end
          3'd1, 3'd2, 3'd3: begin
            r_acc_f <= r_acc_f + ACC_W'(w_prod);
          end
          default: begin
            if (r_en) begin
              r_xh[w_ch][0] <= w_xcur;
              r_xh[w_ch][1] <= r_xh[w_ch][0];
              r_xh[w_ch][2] <= r_xh[w_ch][1];
              r_yh[w_ch][0] <= w_ysat;
              r_yh[w_ch][1] <= r_yh[w_ch][0];
              r_yh[w_ch][2] <= r_yh[w_ch][1];
            end else begin
              for (int k = 0; k < 3; k++) begin
                r_xh[w_ch][k] <= '0;
                r_yh[w_ch][k] <= '0;
              end
            end
            if (!w_ch) begin
              r_y_l <= w_yout;
            end else begin
              r_out_l <= r_y_l;
              r_out_r <= w_yout;
            end
          end
        endcase
      end else begin
        r_step <= '0;
      end
    end
  end

endmodule

// File: tb/tb_arcade_iir_filter.sv
// Scoreboard bench for arcade_iir_filter: a cycle model predicts ticks,
// busy/overrun and queues expected samples; strobes pop and compare.
module tb_arcade_iir_filter;

  localparam int CLK_HZ = 1000;
  localparam int CXS    = 20;
  localparam int CYS    = 21;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               flt_en;
  logic [31:0]        flt_rate;
  logic [39:0]        cx;
  logic [7:0]         cx0, cx1, cx2;
  logic signed [23:0] cy0, cy1, cy2;
  logic signed [15:0] in_l, in_r;
  logic signed [15:0] out_l, out_r;
  logic               out_valid, busy, overrun;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // model state
  bit      m_init = 0;
  longint  m_phase;
  int      m_cnt;
  bit      m_overrun;
  int      m_out_l, m_out_r;
  int      m_xh [2][3];
  int      m_yh [2][3];
  int      q_l[$];
  int      q_r[$];

  arcade_iir_filter #(
    .CLK_HZ  (CLK_HZ),
    .CX_SHIFT(CXS),
    .CY_SHIFT(CYS)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flt_en   (flt_en),
    .flt_rate (flt_rate),
    .cx       (cx),
    .cx0      (cx0),
    .cx1      (cx1),
    .cx2      (cx2),
    .cy0      (cy0),
    .cy1      (cy1),
    .cy2      (cy2),
    .in_l     (in_l),
    .in_r     (in_r),
    .out_l    (out_l),
    .out_r    (out_r),
    .out_valid(out_valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference for one channel: filter step with history update
  function automatic int model_ch(input int ch, input int x);
    longint xs, f;
    logic signed [127:0] cxw, prod, a, yv;
    int y;
    if (!flt_en) begin
      for (int k = 0; k < 3; k++) begin
        m_xh[ch][k] = 0;
        m_yh[ch][k] = 0;
      end
      return x;
    end
    xs = longint'(x) + longint'(cx0) * longint'(m_xh[ch][0])
       + longint'(cx1) * longint'(m_xh[ch][1])
       + longint'(cx2) * longint'(m_xh[ch][2]);
    cxw  = {88'd0, cx};
    prod = cxw * 128'(xs);
    a    = prod >>> CXS;
    f = longint'(cy0) * longint'(m_yh[ch][0])
      + longint'(cy1) * longint'(m_yh[ch][1])
      + longint'(cy2) * longint'(m_yh[ch][2]);
    yv = a - 128'(f >>> CYS);
    if (yv > 32767) y = 32767;
    else if (yv < -32768) y = -32768;
    else y = int'(yv);
    m_xh[ch][2] = m_xh[ch][1];
    m_xh[ch][1] = m_xh[ch][0];
    m_xh[ch][0] = x;
    m_yh[ch][2] = m_yh[ch][1];
    m_yh[ch][1] = m_yh[ch][0];
    m_yh[ch][0] = y;
    return y;
  endfunction

  // Cycle model and per-cycle output comparison
  always @(negedge clk) begin
    bit     exp_v, busy_now, tick;
    longint sum;
    if (m_init) begin
      exp_v = (m_cnt == 1);
      if (exp_v && q_l.size() > 0) begin
        m_out_l = q_l.pop_front();
        m_out_r = q_r.pop_front();
      end
      check_eq("out_valid", longint'(out_valid), longint'(exp_v));
      check_eq("busy", longint'(busy), longint'(m_cnt != 0));
      check_eq("overrun", longint'(overrun), longint'(m_overrun));
      check_eq("out_l", longint'(out_l), longint'(m_out_l));
      check_eq("out_r", longint'(out_r), longint'(m_out_r));
    end
    if (!reset_n) begin
      m_init    = 1;
      m_phase   = 0;
      m_cnt     = 0;
      m_overrun = 0;
      m_out_l   = 0;
      m_out_r   = 0;
      q_l.delete();
      q_r.delete();
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 3; k++) begin
          m_xh[c][k] = 0;
          m_yh[c][k] = 0;
        end
    end else if (m_init) begin
      sum      = m_phase + longint'(flt_rate);
      tick     = (sum >= CLK_HZ);
      m_phase  = tick ? sum - CLK_HZ : sum;
      busy_now = (m_cnt != 0);
      if (m_cnt > 0) m_cnt--;
      if (tick) begin
        if (busy_now) begin
          m_overrun = 1;
        end else begin
          q_l.push_back(model_ch(0, int'(in_l)));
          q_r.push_back(model_ch(1, int'(in_r)));
          m_cnt = 11;
        end
      end
    end
  end

  // Wait (bounded) for a strobe; returns at the negedge where it is high
  task automatic wait_strobe(input string tag);
    int n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t_prev;
    int binom [5] = '{100, 300, 300, 100, 0};
    int fb    [4] = '{1000, 1500, 1750, 1875};

    reset_n  = 1'b0;
    flt_en   = 1'b0;
    flt_rate = 32'd50;
    cx       = 40'd1 << 20;
    cx0      = 8'd0;
    cx1      = 8'd0;
    cx2      = 8'd0;
    cy0      = '0;
    cy1      = '0;
    cy2      = '0;
    in_l     = 16'sd1234;
    in_r     = -16'sd1234;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_out_l", longint'(out_l), 0);
    reset_n = 1'b1;

    // Bypass: 20-cycle tick spacing, input passed through
    wait_strobe("bypass");
    t_prev = cyc;
    check_eq("byp_l", longint'(out_l), 1234);
    check_eq("byp_r", longint'(out_r), -1234);
    next_drive();
    for (int i = 0; i < 2; i++) begin
      wait_strobe("bypass");
      check_eq("byp_period", longint'(cyc - t_prev), 20);
      check_eq("byp_l", longint'(out_l), 1234);
      t_prev = cyc;
      next_drive();
    end

    // Unity filter
    flt_en = 1'b1;
    in_l   = -16'sd500;
    in_r   = 16'sd700;
    for (int i = 0; i < 3; i++) begin
      wait_strobe("unity");
      check_eq("unity_l", longint'(out_l), -500);
      check_eq("unity_r", longint'(out_r), 700);
      next_drive();
    end

    // Binomial FIR impulse, preceded by one bypass tick to clear history
    flt_en = 1'b0;
    wait_strobe("clear");
    next_drive();
    flt_en = 1'b1;
    cx0 = 8'd3;
    cx1 = 8'd3;
    cx2 = 8'd1;
    in_l = 16'sd100;
    in_r = 16'sd0;
    for (int i = 0; i < 5; i++) begin
      wait_strobe("binom");
      check_eq("binom_l", longint'(out_l), longint'(binom[i]));
      next_drive();
      in_l = 16'sd0;
    end

    // Feedback step response
    flt_en = 1'b0;
    wait_strobe("clear");
    next_drive();
    flt_en = 1'b1;
    cx0 = 8'd0;
    cx1 = 8'd0;
    cx2 = 8'd0;
    cy0 = -24'sd1048576;
    in_l = 16'sd1000;
    in_r = -16'sd1000;
    for (int i = 0; i < 5; i++) begin
      wait_strobe("fb");
      if (i < 4) check_eq("fb_l", longint'(out_l), longint'(fb[i]));
      next_drive();
    end

    // Saturation
    cy0  = '0;
    cx   = 40'd1 << 22;
    in_l = 16'sd10000;
    in_r = -16'sd10000;
    for (int i = 0; i < 2; i++) begin
      wait_strobe("sat");
      check_eq("sat_l", longint'(out_l), 32767);
      check_eq("sat_r", longint'(out_r), -32768);
      next_drive();
    end

    // Overrun: ticks every 10 cycles
    check_eq("ovr_pre", longint'(overrun), 0);
    flt_rate = 32'd100;
    repeat (60) @(posedge clk);
    #1;
    check_eq("ovr_set", longint'(overrun), 1);
    repeat (20) @(posedge clk);
    #1;
    check_eq("ovr_sticky", longint'(overrun), 1);

    // Reset during CALC_R, then the impulse again
    flt_rate = 32'd50;
    cx  = 40'd1 << 20;
    cx0 = 8'd3;
    cx1 = 8'd3;
    cx2 = 8'd1;
    in_l = 16'sd100;
    in_r = 16'sd0;
    begin
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      n = 0;
      while (busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      check_eq("mid_busy_seen", longint'(busy), 1);
    end
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_busy", longint'(busy), 0);
    check_eq("mid_out_l", longint'(out_l), 0);
    check_eq("mid_valid", longint'(out_valid), 0);
    check_eq("mid_ovr", longint'(overrun), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_strobe("binom2");
      check_eq("binom2_l", longint'(out_l), longint'(binom[i]));
      next_drive();
      in_l = 16'sd0;
    end
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
